// File: rtl/game_pkg.sv
// Shared constants for the round timer: FSM state encoding, default round
// length and BCD digit helpers.
package game_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;
  localparam logic [1:0] ST_EXPIRED = 2'b11;

  localparam logic [2*BCD_W-1:0] GAME_DEFAULT_SECS = 8'h30;

  // Out-of-range BCD nibbles saturate at 9 rather than being rejected.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD seconds counter: clamped load, saturating decrement at 00,
// plus zero and "about to hit zero" flags for the controller.
module bcd_down_counter2
  import game_pkg::*;
#(
  parameter logic [2*BCD_W-1:0] RESET_VAL = GAME_DEFAULT_SECS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2*BCD_W-1:0] load_val,
  input  logic               dec,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   ones,
  output logic               zero,
  output logic               at_one
);

  assign zero   = (tens == 4'd0) && (ones == 4'd0);
  assign at_one = (tens == 4'd0) && (ones == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens <= RESET_VAL[2*BCD_W-1:BCD_W];
      ones <= RESET_VAL[BCD_W-1:0];
    end else if (load) begin
      tens <= clamp_digit(load_val[2*BCD_W-1:BCD_W]);
      ones <= clamp_digit(load_val[BCD_W-1:0]);
    end else if (dec && !zero) begin
      if (ones != 4'd0) begin
        ones <= ones - 4'd1;
      end else begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_round_timer_ctrl.sv
// Round countdown controller: command sequencing FSM and one-second
// prescaler around a BCD seconds counter; every status output is a flop.
module game_round_timer_ctrl
  import game_pkg::*;
#(
  parameter int                 CLKS_PER_SEC = 50_000_000,
  parameter logic [2*BCD_W-1:0] DEFAULT_SECS = GAME_DEFAULT_SECS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               LoadIn,
  input  logic [2*BCD_W-1:0] LoadVal,
  input  logic               StartIn,
  input  logic               PauseIn,
  input  logic               AbortIn,
  output logic [BCD_W-1:0]   TensDigit,
  output logic [BCD_W-1:0]   OnesDigit,
  output logic               Running,
  output logic               Paused,
  output logic               OneSecTick,
  output logic               Timeout,
  output logic               Expired,
  output logic [1:0]         state_dbg
);

  localparam int PS_W = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_SEC - 1);

  logic [1:0]         state, state_nxt;
  logic [PS_W-1:0]    ps, ps_nxt;
  logic               cnt_load, cnt_dec, cnt_zero, cnt_at_one;
  logic [2*BCD_W-1:0] cnt_load_val;
  logic               tick_nxt, timeout_nxt;

  bcd_down_counter2 #(.RESET_VAL(DEFAULT_SECS)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .tens     (TensDigit),
    .ones     (OnesDigit),
    .zero     (cnt_zero),
    .at_one   (cnt_at_one)
  );

  // Commands not accepted in the current state are ignored, so a lower
  // priority command still acts when a higher one is inapplicable.
  always_comb begin
    state_nxt    = state;
    ps_nxt       = ps;
    cnt_load     = 1'b0;
    cnt_load_val = LoadVal;
    cnt_dec      = 1'b0;
    tick_nxt     = 1'b0;
    timeout_nxt  = 1'b0;
    if (AbortIn) begin
      state_nxt    = ST_IDLE;
      ps_nxt       = '0;
      cnt_load     = 1'b1;
      cnt_load_val = DEFAULT_SECS;
    end else begin
      case (state)
        ST_IDLE: begin
          if (LoadIn) begin
            cnt_load = 1'b1;
            ps_nxt   = '0;
          end else if (StartIn) begin
            if (cnt_zero) begin
              state_nxt   = ST_EXPIRED;
              timeout_nxt = 1'b1;
            end else begin
              state_nxt = ST_RUN;
            end
          end
        end
        ST_PAUSED: begin
          if (LoadIn) begin
            cnt_load = 1'b1;
            ps_nxt   = '0;
          end else if (StartIn && !cnt_zero) begin
            state_nxt = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          if (LoadIn) begin
            cnt_load  = 1'b1;
            ps_nxt    = '0;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          if (ps == PS_LAST) begin
            // The decrement lands before a coincident pause; expiry wins.
            ps_nxt   = '0;
            cnt_dec  = 1'b1;
            tick_nxt = 1'b1;
            if (cnt_at_one) begin
              state_nxt   = ST_EXPIRED;
              timeout_nxt = 1'b1;
            end else if (PauseIn) begin
              state_nxt = ST_PAUSED;
            end
          end else if (PauseIn) begin
            state_nxt = ST_PAUSED;
          end else begin
            ps_nxt = ps + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ps         <= '0;
      Running    <= 1'b0;
      Paused     <= 1'b0;
      Expired    <= 1'b0;
      OneSecTick <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ps         <= ps_nxt;
      Running    <= (state_nxt == ST_RUN);
      Paused     <= (state_nxt == ST_PAUSED);
      Expired    <= (state_nxt == ST_EXPIRED);
      OneSecTick <= tick_nxt;
      Timeout    <= timeout_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/game_round_timer_ctrl.md
Name: game_round_timer_ctrl

Overview:
Controller for the game's per-round countdown resource. It owns a 2-digit BCD seconds counter and the one-second prescaler. It sequences load, start, pause, resume and abort, and reports expiry to the game FSM. It sits between the game controller (command pulses) and the seven-segment display path (digit outputs).

Parameters:
CLKS_PER_SEC, 50_000_000, clk cycles per one-second tick (min 2)
DEFAULT_SECS, 8'h30, BCD value restored on reset/abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
LoadIn  in  1  pulse: load LoadVal into counter
LoadVal  in  8  BCD seconds [7:4] tens, [3:0] ones
StartIn  in  1  pulse: start or resume countdown
PauseIn  in  1  pulse: pause countdown
AbortIn  in  1  pulse: return to IDLE, counter := DEFAULT_SECS
TensDigit  out  4  current tens digit
OnesDigit  out  4  current ones digit
Running  out  1  high in RUN
Paused  out  1  high in PAUSED
OneSecTick  out  1  one-cycle pulse per elapsed second while running
Timeout  out  1  one-cycle pulse on expiry
Expired  out  1  level, high in EXPIRED

Behaviour:
- Reset (async, rst=1):
  - state IDLE
  - {TensDigit,OnesDigit}=DEFAULT_SECS, prescaler=0
  - Running=Paused=OneSecTick=Timeout=Expired=0
- All outputs are registered.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Command priority within a cycle: AbortIn > LoadIn > StartIn > PauseIn.
- AbortIn, any state: next state IDLE, counter=DEFAULT_SECS, prescaler=0, Timeout suppressed.
- LoadIn:
  - Accepted in IDLE, PAUSED and EXPIRED. Ignored in RUN.
  - Any BCD digit >9 is clamped to 9.
  - Prescaler cleared.
  - From EXPIRED the next state is IDLE. Otherwise the state is unchanged.
- StartIn:
  - IDLE or PAUSED with counter != 00 -> RUN; prescaler retains its value (resume is seamless).
  - IDLE with counter == 00 -> EXPIRED, Timeout pulses 1 cycle later.
  - Ignored in RUN and EXPIRED.
- PauseIn: RUN -> PAUSED; prescaler frozen. Ignored in other states.
- Prescaler:
  - Increments only in RUN, range 0..CLKS_PER_SEC-1, wraps to 0.
  - The wrap cycle raises OneSecTick on the following cycle.
- Tick decrement (BCD):
  - ones!=0: ones-1.
  - ones==0: ones=9, tens-1.
- Expiry: a tick that brings the counter to 00 moves the state to EXPIRED in the same update; Timeout=1 for exactly one cycle; Expired=1 until Abort or Load.
- Counter never wraps below 00.
- PauseIn coincident with an internal tick: the decrement is applied first, then PAUSED. If that decrement reaches 00, the state goes to EXPIRED (expiry wins).
- Latency:
  - Start to first tick = CLKS_PER_SEC cycles from a cleared prescaler.
  - Command to status output: 1 cycle.
- Reset asserted mid-count returns everything to the reset values immediately; no Timeout pulse.

Decomposition:
- Shared package game_pkg: state encoding constants (IDLE=2'b00, RUN=2'b01, PAUSED=2'b10, EXPIRED=2'b11), DEFAULT_SECS, BCD digit width.
- Sub-module bcd_down_counter2: 2-digit BCD decrement with load, clamp and zero flag. The FSM and prescaler stay in the top level.

Test Plan:
- CLKS_PER_SEC=4, reset released:
  - digits 3,0; all flags 0.
  - StartIn -> Running=1; after 4 cycles OneSecTick pulses; digits 2,9.
- LoadVal=8'h02, StartIn -> ticks at 4 and 8 cycles; digits 01 then 00; Timeout pulses once coincident with Expired rising; Running=0.
- Running, PauseIn at prescaler=2 -> Paused=1, digits held for 20 cycles; StartIn -> next tick arrives 2 cycles later (prescaler retained).
- LoadVal=8'hAF -> digits 9,9 (clamp). Same cycle LoadIn+StartIn+AbortIn -> IDLE with digits 3,0.
- IDLE, LoadVal=8'h00, StartIn -> EXPIRED and Timeout pulse without any tick. LoadIn in EXPIRED -> IDLE, Expired=0.
- rst pulse (asynchronous, mid-cycle) during RUN at digits 1,5 -> outputs reset immediately; no Timeout; Running=0.
